// File: rtl/io_port_pkg.sv
// Shared constants for the uP I/O stage: port width, read-mode encodings, debounce defaults.
package io_port_pkg;
  localparam int IO_W = 4;
  localparam int DEB_CYCLES_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 5;
  localparam logic IN_MODE_LEVEL = 1'b0;
  localparam logic IN_MODE_EVENT = 1'b1;
endpackage

// File: rtl/io_port_if.sv
// Decoder/data-bus side of the I/O stage; master = decoder, slave = io_port.
interface io_port_if;
  import io_port_pkg::*;
  logic            in_en;
  logic            in_mode;
  logic            out_en;
  logic [IO_W-1:0] data_bus_in;
  logic [IO_W-1:0] data_bus_out;
  logic            data_bus_oe;

  modport master (
    output in_en, in_mode, out_en, data_bus_in,
    input  data_bus_out, data_bus_oe
  );
  modport slave (
    input  in_en, in_mode, out_en, data_bus_in,
    output data_bus_out, data_bus_oe
  );
endinterface

// File: rtl/io_debounce.sv
// One button: 2-FF synchronizer plus stability counter; stable follows after DEB_CYCLES agreeing cycles.
// Latency 2+DEB_CYCLES edges from raw change to stable; no backpressure.
module io_debounce
  import io_port_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (s2 != stable) && (cnt == CNT_W'(DEB_CYCLES - 1));
  // Combinational so the event flag sets on the same edge that stable rises.
  assign rise   = accept && s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/io_port.sv
// uP I/O stage: debounced buttons readable as levels or sticky press events; FF_out latches the bus.
// Bus read is combinational, FF_out valid one edge after out_en; no backpressure.
module io_port
  import io_port_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IO_W-1:0] pushbuttons,
  io_port_if.slave        bus,
  output logic [IO_W-1:0] FF_out,
  output logic [IO_W-1:0] btn_state,
  output logic [IO_W-1:0] btn_event
);
  logic [IO_W-1:0] stable;
  logic [IO_W-1:0] rise;
  logic            ev_clear;

  for (genvar i = 0; i < IO_W; i++) begin : g_bit
    io_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .raw    (pushbuttons[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  assign btn_state = stable;
  assign ev_clear  = bus.in_en && (bus.in_mode == IN_MODE_EVENT);

  assign bus.data_bus_oe  = bus.in_en;
  assign bus.data_bus_out = !bus.in_en ? '0 :
                            (bus.in_mode == IN_MODE_EVENT) ? btn_event : btn_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_event <= '0;
      FF_out    <= '0;
    end else begin
      // Clear first, then OR in new presses so a simultaneous press survives.
      btn_event <= (btn_event & ~{IO_W{ev_clear}}) | rise;
      if (bus.out_en) begin
        FF_out <= bus.data_bus_in;
      end
    end
  end
endmodule
